// File: rtl/signed_alu_pkg.sv
// Shared constants for the signed ALU with BCD display: opcodes, FSM states,
// active-low seven-segment glyphs and the digit-to-glyph lookup.
package signed_alu_pkg;

    typedef enum logic {IDLE, CONV} state_t;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// bcd and done describe the iteration happening this cycle, so the caller
// can capture the final digits on the same edge the last iteration retires.
module bin2bcd_seq #(
    parameter int NBITS  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [NBITS-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(NBITS);

    logic [NBITS-1:0]    shift_q;
    logic [4*DIGITS-1:0] digits_q;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt_q;

    always_comb begin
        adj = digits_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
        end
    end

    assign bcd  = {adj[4*DIGITS-2:0], shift_q[NBITS-1]};
    assign done = busy && (cnt_q == CW'(NBITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            digits_q <= '0;
        end else if (load) begin
            busy     <= 1'b1;
            cnt_q    <= '0;
            shift_q  <= value;
            digits_q <= '0;
        end else if (busy) begin
            digits_q <= bcd;
            shift_q  <= {shift_q[NBITS-2:0], 1'b0};
            cnt_q    <= cnt_q + CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/signed_alu_bcd_seq.sv
// Signed ALU whose registered result is shown in decimal on active-low
// seven-segment glyphs, updated once the sequential BCD conversion finishes.
module signed_alu_bcd_seq
    import signed_alu_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            sel,
    input  logic                  start,
    output logic [2*WIDTH-1:0]    y,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            seg_sign
);

    localparam int YW = 2 * WIDTH;

    state_t              state;
    logic [YW-1:0]       ax, bx, alu, mag;
    logic                accept;
    logic                conv_busy, conv_done;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [7*DIGITS-1:0] seg_next;

    assign ax = {{WIDTH{a[WIDTH-1]}}, a};
    assign bx = {{WIDTH{b[WIDTH-1]}}, b};

    // Modular 2*WIDTH arithmetic on sign-extended operands yields the exact signed result.
    always_comb begin
        case (sel)
            OP_ZERO: alu = '0;
            OP_AND:  alu = ax & bx;
            OP_OR:   alu = ax | bx;
            OP_XOR:  alu = ax ^ bx;
            OP_NOT:  alu = ~ax;
            OP_SUB:  alu = ax - bx;
            OP_ADD:  alu = ax + bx;
            OP_MUL:  alu = ax * bx;
            default: alu = '0;
        endcase
    end

    assign mag    = alu[YW-1] ? (~alu + YW'(1)) : alu;
    assign accept = (state == IDLE) && start;

    bin2bcd_seq #(
        .NBITS  (YW),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .value (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        seg_next = '1;
        for (int unsigned i = 0; i < DIGITS; i++)
            seg_next[7*i +: 7] = digit_glyph(conv_bcd[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg      <= {DIGITS{SEG_0}};
            seg_sign <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        y     <= alu;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (conv_busy && conv_done) begin
                        seg      <= seg_next;
                        seg_sign <= y[YW-1] ? SEG_MINUS : SEG_BLANK;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_alu_bcd_seq.sv
// Self-checking bench: directed vector table and corner sequences on WIDTH=5,
// plus random operations on WIDTH=4/5/7 against an arithmetic reference model.
module tb_signed_alu_bcd_seq;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] MI = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    logic [6:0] gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  a4, b4;   logic [2:0] sel4; logic start4;
    logic [7:0]  y4;       logic busy4, done4; logic [20:0] seg4; logic [6:0] sgn4;
    logic [4:0]  a5, b5;   logic [2:0] sel5; logic start5;
    logic [9:0]  y5;       logic busy5, done5; logic [20:0] seg5; logic [6:0] sgn5;
    logic [6:0]  a7, b7;   logic [2:0] sel7; logic start7;
    logic [13:0] y7;       logic busy7, done7; logic [34:0] seg7; logic [6:0] sgn7;

    signed_alu_bcd_seq #(.WIDTH(4), .DIGITS(3)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .sel(sel4), .start(start4),
        .y(y4), .busy(busy4), .done(done4), .seg(seg4), .seg_sign(sgn4));
    signed_alu_bcd_seq #(.WIDTH(5), .DIGITS(3)) u5 (
        .clk(clk), .rst(rst), .a(a5), .b(b5), .sel(sel5), .start(start5),
        .y(y5), .busy(busy5), .done(done5), .seg(seg5), .seg_sign(sgn5));
    signed_alu_bcd_seq #(.WIDTH(7), .DIGITS(5)) u7 (
        .clk(clk), .rst(rst), .a(a7), .b(b7), .sel(sel7), .start(start7),
        .y(y7), .busy(busy7), .done(done7), .seg(seg7), .seg_sign(sgn7));

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        longint m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    function automatic longint ref_alu(input int w, input int s, input longint av, input longint bv);
        longint x = sx(av, w);
        longint z = sx(bv, w);
        case (s)
            1: return x & z;
            2: return x | z;
            3: return x ^ z;
            4: return ~x;
            5: return x - z;
            6: return x + z;
            7: return x * z;
            default: return 0;
        endcase
    endfunction

    function automatic int glyph_val(input logic [6:0] g);
        for (int k = 0; k < 10; k++)
            if (g == gl[k]) return k;
        return -1;
    endfunction

    function automatic longint disp_val(input logic [34:0] s, input int nd);
        longint v = 0;
        longint p = 1;
        logic [6:0] g;
        for (int i = 0; i < nd; i++) begin
            g = s[7*i +: 7];
            if (glyph_val(g) < 0) return -1;
            v = v + glyph_val(g) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic longint get_y(input int inst);
        case (inst)
            4: return longint'($signed(y4));
            5: return longint'($signed(y5));
            default: return longint'($signed(y7));
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 4) ? done4 : (inst == 5) ? done5 : done7;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 4) ? busy4 : (inst == 5) ? busy5 : busy7;
    endfunction

    function automatic longint get_disp(input int inst);
        case (inst)
            4: return disp_val(35'(seg4), 3);
            5: return disp_val(35'(seg5), 3);
            default: return disp_val(seg7, 5);
        endcase
    endfunction

    function automatic logic [6:0] get_sign(input int inst);
        return (inst == 4) ? sgn4 : (inst == 5) ? sgn5 : sgn7;
    endfunction

    task automatic drive(input int inst, input int s, input longint av, input longint bv, input logic st);
        case (inst)
            4: begin sel4 = 3'(s); a4 = av[3:0]; b4 = bv[3:0]; start4 = st; end
            5: begin sel5 = 3'(s); a5 = av[4:0]; b5 = bv[4:0]; start5 = st; end
            default: begin sel7 = 3'(s); a7 = av[6:0]; b7 = bv[6:0]; start7 = st; end
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run_op(input int inst, input int w, input int s, input longint av,
                          input longint bv, output int lat);
        bit seen = 0;
        lat = -1;
        drive(inst, s, av, bv, 1'b1);
        @(posedge clk); #1;
        drive(inst, s, av, bv, 1'b0);
        chk("busy_after_start", longint'(get_busy(inst)), 1);
        for (int n = 1; n <= 4 * w + 8; n++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (get_done(inst)) begin
                    seen = 1;
                    lat = n;
                end
            end
        end
    endtask

    typedef struct {
        int         sel;
        int         a;
        int         b;
        int         y;
        logic [20:0] seg;
        logic [6:0] sgn;
    } vec_t;

    vec_t tv [8];

    initial begin
        int lat, cyc;
        bit seen, seg_held, y_held;
        logic [20:0] prev_seg;
        longint av, bv, r, mag;
        int w, s, done_cnt;

        tv[0] = '{7, -16, -16, 256, {G2, G5, G6}, BL};
        tv[1] = '{5, -16,  15, -31, {G0, G3, G1}, MI};
        tv[2] = '{4,   5,   0,  -6, {G0, G0, G6}, MI};
        tv[3] = '{0,   3,   7,   0, {G0, G0, G0}, BL};
        tv[4] = '{1,  -1,  10,  10, {G0, G1, G0}, BL};
        tv[5] = '{2,   8,   3,  11, {G0, G1, G1}, BL};
        tv[6] = '{3,  -1,   5,  -6, {G0, G0, G6}, MI};
        tv[7] = '{6,  15,  15,  30, {G0, G3, G0}, BL};

        rst = 1'b1;
        drive(4, 0, 0, 0, 1'b0);
        drive(5, 0, 0, 0, 1'b0);
        drive(7, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", get_y(5), 0);
        chk("reset_busy", longint'(busy5), 0);
        chk("reset_done", longint'(done5), 0);
        chk("reset_seg", longint'(seg5), longint'({G0, G0, G0}));
        chk("reset_sign", longint'(sgn5), longint'(BL));
        chk("reset_seg_w7", longint'(seg7), longint'({G0, G0, G0, G0, G0}));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(5, 5, tv[i].sel, longint'(tv[i].a), longint'(tv[i].b), lat);
            chk("vec_latency", lat, 10);
            chk("vec_y", get_y(5), longint'(tv[i].y));
            chk("vec_seg", longint'(seg5), longint'(tv[i].seg));
            chk("vec_sign", longint'(sgn5), longint'(tv[i].sgn));
            chk("vec_busy_at_done", longint'(busy5), 0);
            @(posedge clk); #1;
            chk("vec_done_one_cycle", longint'(done5), 0);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        prev_seg = seg5;
        seg_held = 1;
        y_held = 1;
        seen = 0;
        cyc = 0;
        drive(5, 7, -16, -16, 1'b1);
        @(posedge clk); #1;
        drive(5, 7, -16, -16, 1'b0);
        cyc = 1;
        while (!seen && cyc < 40) begin
            if (cyc == 3) drive(5, 6, 1, 1, 1'b1);
            if (cyc == 4) drive(5, 6, 1, 1, 1'b0);
            if (seg5 != prev_seg) seg_held = 0;
            if (get_y(5) != 256) y_held = 0;
            @(posedge clk); #1;
            cyc++;
            if (done5) seen = 1;
        end
        chk("busy_start_latency", seen ? cyc - 1 : -1, 10);
        chk("busy_start_y_held", longint'(y_held), 1);
        chk("seg_held_during_conv", longint'(seg_held), 1);
        chk("busy_start_y", get_y(5), 256);
        chk("busy_start_seg", longint'(seg5), longint'({G2, G5, G6}));
        drive(5, 6, 1, 1, 1'b1);
        @(posedge clk); #1;
        drive(5, 6, 1, 1, 1'b0);
        chk("done_cycle_start_busy", longint'(busy5), 1);
        chk("done_cycle_start_y", get_y(5), 2);
        chk("done_cycle_done_low", longint'(done5), 0);
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (done5) seen = 1;
            end
        end
        chk("done_cycle_op_done", longint'(seen), 1);
        chk("done_cycle_op_seg", longint'(seg5), longint'({G0, G0, G2}));

        // Reset mid-conversion aborts without a done pulse.
        drive(5, 5, -16, 15, 1'b1);
        @(posedge clk); #1;
        drive(5, 5, -16, 15, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", longint'(busy5), 0);
        chk("abort_y", get_y(5), 0);
        chk("abort_seg", longint'(seg5), longint'({G0, G0, G0}));
        chk("abort_sign", longint'(sgn5), longint'(BL));
        done_cnt = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (done5) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);

        // Random operations on all three widths.
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 4 : (k == 1) ? 5 : 7;
            for (int n = 0; n < 30; n++) begin
                s  = int'($urandom_range(0, 7));
                av = sx(longint'($urandom_range(0, (1 << w) - 1)), w);
                bv = sx(longint'($urandom_range(0, (1 << w) - 1)), w);
                r  = ref_alu(w, s, av, bv);
                mag = (r < 0) ? -r : r;
                run_op(w, w, s, av, bv, lat);
                chk("rand_latency", lat, 2 * w);
                chk("rand_y", get_y(w), r);
                chk("rand_digits", get_disp(w), mag);
                chk("rand_sign", longint'(get_sign(w)), (r < 0) ? longint'(MI) : longint'(BL));
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/signed_alu_bcd_seq.md
SIGNED_ALU_BCD_SEQ -- requirements
Module: signed_alu_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5: operand width in bits, two's complement, minimum 2.
REQ-002 The block SHALL have parameter DIGITS, default 3: number of decimal digits shown; integrator guarantees 10**DIGITS > 2**(2*WIDTH-1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 a, b  in  WIDTH  signed operands, sampled only on an accepted start.
REQ-007 sel  in  3  opcode, sampled only on an accepted start.
REQ-008 start  in  1  operation request.
REQ-009 y  out  2*WIDTH  signed registered result.
REQ-010 busy  out  1  conversion in progress.
REQ-011 done  out  1  one-cycle pulse when the display outputs have been updated.
REQ-012 seg  out  7*DIGITS  active-low digit glyphs; bits [6:0] are ones, the next 7 bits are tens, and so on.
REQ-013 seg_sign  out  7  minus glyph 0111111 when the result is negative, otherwise blank 1111111.

Function
REQ-014 Opcodes SHALL be: 000 zero; 001 a&b; 010 a|b; 011 a^b; 100 ~a; 101 a-b; 110 a+b; 111 a*b.
REQ-015 Operands SHALL be sign-extended to 2*WIDTH bits before any operation; the full-width signed result cannot overflow.
REQ-016 States SHALL be IDLE and CONV.
REQ-017 In IDLE with start=1 at edge E0, the block SHALL:
- register the result into y;
- load |y| into the shift register and clear the BCD digits;
- set busy=1 and enter CONV.
REQ-018 In CONV the block SHALL run one double-dabble iteration per edge (add 3 to any digit >=5, then shift left one bit, MSB first) at edges E1..E(2*WIDTH).
REQ-019 At edge E(2*WIDTH) the block SHALL:
- write seg and seg_sign from the final BCD digits and the sign of y;
- set done=1 and busy=0;
- return to IDLE.
Latency from start to done is 2*WIDTH cycles.
REQ-020 done SHALL be high for exactly one cycle; start in the cycle done is high SHALL be accepted normally.
REQ-021 start while busy=1 SHALL be ignored; y, seg and the in-flight conversion remain unaffected.
REQ-022 seg and seg_sign SHALL hold their last values throughout CONV; a new value appears only on the done edge.
REQ-023 Magnitude of the most negative result (-(2**(2*WIDTH-1))) SHALL convert correctly as unsigned 2*WIDTH bits.
REQ-024 Glyphs SHALL be active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, non-BCD=1111111.
REQ-025 Leading zeros SHALL be displayed, not blanked.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set:
- y=0, busy=0, done=0, state=IDLE;
- every seg digit to glyph 0 (1000000);
- seg_sign=1111111.
REQ-027 Reset SHALL take priority over start and abort any conversion in progress; no done pulse is issued for an aborted conversion.

Structure
REQ-028 A package signed_alu_pkg SHALL hold:
- opcode constants;
- the glyph constants, including SEG_MINUS and SEG_BLANK;
- the digit-to-glyph function.
REQ-029 The sequential converter SHALL be a sub-module bin2bcd_seq (parameters NBITS and DIGITS; ports load, value, busy, done, bcd). The top SHALL contain the ALU, the control FSM and the glyph registers.

Verification (WIDTH=5, DIGITS=3)
REQ-030 sel=111, a=-16, b=-16, start -> y=256; done exactly 10 cycles later; seg digits 2,5,6 = 0100100, 0010010, 0000010; seg_sign=1111111.
REQ-031 sel=101, a=-16, b=15 -> y=-31; seg_sign=0111111; digits 0,3,1.
REQ-032 sel=100, a=5 -> y=-6 with digits 0,0,6 and minus sign; then sel=000 -> y=0 with digits 0,0,0 and blank sign.
REQ-033 Second start (sel=110, a=1, b=1) issued 3 cycles into a conversion -> ignored; the first result completes unchanged; start asserted in the done cycle -> accepted, busy=1 next cycle.
REQ-034 rst asserted 4 cycles into a conversion -> next cycle busy=0, y=0, seg = 0,0,0 glyphs; no done pulse is ever issued for the aborted operation.
REQ-035 Parameter sweep WIDTH=4/DIGITS=3 and WIDTH=7/DIGITS=5, all opcodes on random operands -> y and decoded digits match a reference model; done latency = 2*WIDTH cycles.
